uart_tx_arbiter: RTL

Round-robin scheduler that shares one `uart_byte_tx` engine between `N_REQ` byte requesters. It grants one requester at a time and latches that requester's byte. It launches the engine with a single-cycle `send_en`, waits for `tx_done`, and returns a per-requester completion pulse. A watchdog aborts a transfer whose `tx_done` never arrives. The block sits between on-chip byte producers and `uart_byte_tx`; `baud_set` is routed to the engine outside this block.

---
 rtl/uart_tx_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one uart_byte_tx engine between N_REQ byte producers. Requests
//   are served round-robin. The winning byte is latched and the engine is
//   launched with a one-cycle send_en. The block then waits for tx_done and
//   returns a per-requester done pulse. A watchdog aborts the transfer with
//   err if tx_done never arrives.
//
// Ports
//   clk, rstn     clock, asynchronous active-low reset
//   req           per-requester level request, held until its gnt
//   req_data      byte i on [8i+7:8i]
//   gnt           one-hot acceptance pulse (coincides with send_en)
//   done          one-hot completion pulse, the cycle after tx_done
//   err           watchdog abort pulse
//   busy          high whenever the FSM is not in IDLE
//   send_en/data  engine start pulse and byte (data held until IDLE)
//   tx_done       engine end-of-frame pulse
//   uart_state    engine frame-in-progress level
module uart_tx_arbiter #(
    parameter int N_REQ   = 4,
    parameter int TIMEOUT = 1048575
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [N_REQ-1:0]   done,
    output logic               err,
    output logic               busy,
    output logic               send_en,
    output logic [7:0]         data,
    input  logic               tx_done,
    input  logic               uart_state
);

    localparam int PW   = $clog2(N_REQ);
    // wd only counts up to TIMEOUT-1
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT, DRAIN} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      ptr_q, ptr_d;
    logic [PW-1:0]      cur_q, cur_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [7:0]         data_q, data_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic [N_REQ-1:0]   done_q, done_d;
    logic               err_q, err_d;
    logic               busy_q, busy_d;
    logic               send_en_q, send_en_d;

    logic [PW-1:0]      win;
    logic               win_vld;
    logic [PW-1:0]      cand;

    // Round-robin search starting one past the last served requester.
    always_comb begin
        win     = ptr_q;
        win_vld = 1'b0;
        cand    = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            cand = PW'((int'(ptr_q) + i) % N_REQ);
            if (!win_vld && req[cand]) begin
                win_vld = 1'b1;
                win     = cand;
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cur_d     = cur_q;
        wd_d      = wd_q;
        data_d    = data_q;
        gnt_d     = '0;
        done_d    = '0;
        err_d     = 1'b0;
        send_en_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (win_vld) begin
                    data_d    = req_data[8*win +: 8];
                    cur_d     = win;
                    gnt_d     = {{(N_REQ-1){1'b0}}, 1'b1} << win;
                    send_en_d = 1'b1;
                    state_d   = LAUNCH;
                end
            end
            LAUNCH: begin
                wd_d    = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // tx_done has priority over a coincident timeout
                if (tx_done) begin
                    done_d[cur_q] = 1'b1;
                    ptr_d         = cur_q;
                    state_d       = DRAIN;
                end else if (wd_q == WD_W'(TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    ptr_d   = cur_q;
                    state_d = DRAIN;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                end
            end
            DRAIN: begin
                if (!uart_state) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= IDLE;
            ptr_q     <= PW'(N_REQ - 1);
            cur_q     <= '0;
            wd_q      <= '0;
            data_q    <= '0;
            gnt_q     <= '0;
            done_q    <= '0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
            send_en_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cur_q     <= cur_d;
            wd_q      <= wd_d;
            data_q    <= data_d;
            gnt_q     <= gnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
            send_en_q <= send_en_d;
        end
    end

    assign gnt     = gnt_q;
    assign done    = done_q;
    assign err     = err_q;
    assign busy    = busy_q;
    assign send_en = send_en_q;
    assign data    = data_q;

endmodule
